systolic_pe_mac: RTL and testbench

//  Parametrised processing element for the systolic transform array. One instance sits per array column.

---
 rtl/pe_pkg.sv | 32 +++
 rtl/pe_sat_acc.sv | 26 ++
 rtl/systolic_pe_mac.sv | 121 ++++++++++++
 tb/tb_systolic_pe_mac.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared types, default widths and arithmetic helpers for the systolic PE array.
package pe_pkg;

    localparam int unsigned PE_DATA_WIDTH = 8;
    localparam int unsigned PE_COEF_WIDTH = 8;
    localparam int unsigned PE_ACC_WIDTH  = 20;

    typedef enum logic {
        PE_SUM  = 1'b0,
        PE_DIFF = 1'b1
    } pe_mode_e;

    // Signed add of a and b, clamped to the signed range of 'width' bits (width <= 64).
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int unsigned        width);
        logic signed [64:0] s;
        logic signed [64:0] maxV;
        logic signed [64:0] minV;
        s    = {a[63], a} + {b[63], b};
        maxV = (65'sd1 <<< (width - 1)) - 65'sd1;
        minV = -(65'sd1 <<< (width - 1));
        if (s > maxV) begin
            return maxV[63:0];
        end
        if (s < minV) begin
            return minV[63:0];
        end
        return s[63:0];
    endfunction

endpackage

// File: rtl/pe_sat_acc.sv
// Stage-2 accumulate: partial sum plus sign-extended product, with overflow detect and
// optional clamp to the signed ACC_WIDTH range.
module pe_sat_acc #(
    parameter int unsigned ACC_WIDTH = 20,
    parameter bit          SATURATE  = 1'b1
) (
    input  logic [ACC_WIDTH-1:0] zIn,
    input  logic [ACC_WIDTH:0]   addend,
    output logic [ACC_WIDTH-1:0] zOut,
    output logic                 overflow
);

    logic [ACC_WIDTH:0] sum;

    always_comb begin
        sum      = {zIn[ACC_WIDTH-1], zIn} + addend;
        overflow = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
        zOut     = sum[ACC_WIDTH-1:0];
        if (SATURATE && overflow) begin
            // The extra top bit holds the true sign of the unclamped result.
            zOut = sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                  : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
    end

endmodule

// File: rtl/systolic_pe_mac.sv
// Systolic array processing element: pre-add/sub, coefficient multiply, partial-sum
// accumulate, with one-cycle forwarding of data and control to the next PE.
module systolic_pe_mac
    import pe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = PE_DATA_WIDTH,
    parameter int unsigned COEF_WIDTH = PE_COEF_WIDTH,
    parameter int unsigned ACC_WIDTH  = PE_ACC_WIDTH,
    parameter bit          SATURATE   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  validIn,
    input  logic [DATA_WIDTH-1:0] xIn,
    input  logic [DATA_WIDTH-1:0] xDelayIn,
    input  logic [ACC_WIDTH-1:0]  zIn,
    input  logic [COEF_WIDTH-1:0] CoefficientIn,
    input  logic                  sumDiffSelIn,
    input  logic                  loadIn,
    input  logic                  clrOvf,
    output logic                  validOut,
    output logic [DATA_WIDTH-1:0] xOut,
    output logic [DATA_WIDTH-1:0] xDelayOut,
    output logic [ACC_WIDTH-1:0]  zOut,
    output logic [COEF_WIDTH-1:0] CoefficientOut,
    output logic                  sumDiffSelOut,
    output logic                  loadOut,
    output logic                  ovf
);

    localparam int unsigned PROD_WIDTH = DATA_WIDTH + COEF_WIDTH + 1;
    localparam int unsigned SUM_WIDTH  = ACC_WIDTH + 1;

    pe_mode_e mode;

    logic signed [DATA_WIDTH:0]   xExt;
    logic signed [DATA_WIDTH:0]   xDelayExt;
    logic signed [DATA_WIDTH:0]   preD;
    logic signed [COEF_WIDTH-1:0] coefSelD;

    logic signed [DATA_WIDTH:0]   preQ;
    logic signed [COEF_WIDTH-1:0] coefS1Q;
    logic signed [COEF_WIDTH-1:0] coefRegQ;
    logic [ACC_WIDTH-1:0]         zS1Q;
    logic                         validS1Q;

    logic signed [PROD_WIDTH-1:0] prodA;
    logic signed [PROD_WIDTH-1:0] prodB;
    logic signed [PROD_WIDTH-1:0] prod;
    logic signed [SUM_WIDTH-1:0]  prodExt;
    logic [ACC_WIDTH-1:0]         accZ;
    logic                         accOvf;

    // Stage 1: exact pre-add/sub and coefficient select (a load cycle uses its own coefficient).
    always_comb begin
        mode      = pe_mode_e'(sumDiffSelIn);
        xExt      = {xIn[DATA_WIDTH-1], xIn};
        xDelayExt = {xDelayIn[DATA_WIDTH-1], xDelayIn};
        preD      = (mode == PE_DIFF) ? (xExt - xDelayExt) : (xExt + xDelayExt);
        coefSelD  = loadIn ? CoefficientIn : coefRegQ;
    end

    // Stage 2: exact signed product, resized to the accumulator's guard width.
    always_comb begin
        prodA   = PROD_WIDTH'(preQ);
        prodB   = PROD_WIDTH'(coefS1Q);
        prod    = prodA * prodB;
        prodExt = SUM_WIDTH'(prod);
    end

    pe_sat_acc #(
        .ACC_WIDTH (ACC_WIDTH),
        .SATURATE  (SATURATE)
    ) u_acc (
        .zIn      (zS1Q),
        .addend   (prodExt),
        .zOut     (accZ),
        .overflow (accOvf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            preQ           <= '0;
            coefS1Q        <= '0;
            coefRegQ       <= '0;
            zS1Q           <= '0;
            validS1Q       <= 1'b0;
            xOut           <= '0;
            xDelayOut      <= '0;
            CoefficientOut <= '0;
            sumDiffSelOut  <= 1'b0;
            loadOut        <= 1'b0;
            zOut           <= '0;
            validOut       <= 1'b0;
            ovf            <= 1'b0;
        end else if (en) begin
            preQ           <= preD;
            coefS1Q        <= coefSelD;
            if (loadIn) begin
                coefRegQ <= CoefficientIn;
            end
            zS1Q           <= zIn;
            validS1Q       <= validIn;
            xOut           <= xIn;
            xDelayOut      <= xDelayIn;
            CoefficientOut <= CoefficientIn;
            sumDiffSelOut  <= sumDiffSelIn;
            loadOut        <= loadIn;
            zOut           <= accZ;
            validOut       <= validS1Q;
            // Set has priority over clear; invalid samples never set the flag.
            if (validS1Q && accOvf) begin
                ovf <= 1'b1;
            end else if (clrOvf) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_systolic_pe_mac.sv
// Directed bench for systolic_pe_mac: default 20-bit PE plus 16-bit saturating and wrapping PEs.
module tb_systolic_pe_mac;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        validIn;
    logic [7:0]  xIn;
    logic [7:0]  xDelayIn;
    logic [19:0] zIn;
    logic [7:0]  CoefficientIn;
    logic        sumDiffSelIn;
    logic        loadIn;
    logic        clrOvf;

    logic        validOut;
    logic [7:0]  xOut;
    logic [7:0]  xDelayOut;
    logic [19:0] zOut;
    logic [7:0]  CoefficientOut;
    logic        sumDiffSelOut;
    logic        loadOut;
    logic        ovf;

    logic        validOutS, validOutW;
    logic [7:0]  xOutS, xOutW, xDelayOutS, xDelayOutW;
    logic [15:0] zOutS, zOutW;
    logic [7:0]  coefOutS, coefOutW;
    logic        selOutS, selOutW, loadOutS, loadOutW;
    logic        ovfS, ovfW;

    int nCmp  = 0;
    int nFail = 0;

    always #5 clk = ~clk;

    systolic_pe_mac dut (
        .clk(clk), .rst_n(rst_n), .en(en), .validIn(validIn), .xIn(xIn), .xDelayIn(xDelayIn),
        .zIn(zIn), .CoefficientIn(CoefficientIn), .sumDiffSelIn(sumDiffSelIn), .loadIn(loadIn),
        .clrOvf(clrOvf), .validOut(validOut), .xOut(xOut), .xDelayOut(xDelayOut), .zOut(zOut),
        .CoefficientOut(CoefficientOut), .sumDiffSelOut(sumDiffSelOut), .loadOut(loadOut),
        .ovf(ovf)
    );

    systolic_pe_mac #(.ACC_WIDTH(16), .SATURATE(1'b1)) dutSat (
        .clk(clk), .rst_n(rst_n), .en(en), .validIn(validIn), .xIn(xIn), .xDelayIn(xDelayIn),
        .zIn(zIn[15:0]), .CoefficientIn(CoefficientIn), .sumDiffSelIn(sumDiffSelIn),
        .loadIn(loadIn), .clrOvf(clrOvf), .validOut(validOutS), .xOut(xOutS),
        .xDelayOut(xDelayOutS), .zOut(zOutS), .CoefficientOut(coefOutS),
        .sumDiffSelOut(selOutS), .loadOut(loadOutS), .ovf(ovfS)
    );

    systolic_pe_mac #(.ACC_WIDTH(16), .SATURATE(1'b0)) dutWrap (
        .clk(clk), .rst_n(rst_n), .en(en), .validIn(validIn), .xIn(xIn), .xDelayIn(xDelayIn),
        .zIn(zIn[15:0]), .CoefficientIn(CoefficientIn), .sumDiffSelIn(sumDiffSelIn),
        .loadIn(loadIn), .clrOvf(clrOvf), .validOut(validOutW), .xOut(xOutW),
        .xDelayOut(xDelayOutW), .zOut(zOutW), .CoefficientOut(coefOutW),
        .sumDiffSelOut(selOutW), .loadOut(loadOutW), .ovf(ovfW)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic ld, input logic sel, input logic [7:0] c,
                         input logic [7:0] x, input logic [7:0] xd, input logic [19:0] z);
        validIn       = v;
        loadIn        = ld;
        sumDiffSelIn  = sel;
        CoefficientIn = c;
        xIn           = x;
        xDelayIn      = xd;
        zIn           = z;
    endtask

    // Stall-stream sample k: x=k, xd=1, sum mode, z=100k, held coefficient -128.
    function automatic logic [19:0] expZ(input int k);
        return 20'(100 * k - 128 * (k + 1));
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst_n  = 1'b0;
        en     = 1'b1;
        clrOvf = 1'b0;
        drive(0, 0, 0, 8'd0, 8'd0, 8'd0, 20'd0);
        #12;
        check("rst_zOut", 32'(zOut), 0);
        check("rst_validOut", 32'(validOut), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_coefOut", 32'(CoefficientOut), 0);
        rst_n = 1'b1;

        // Sum with load, then diff with held coefficient, then extremes.
        drive(1, 1, 0, 8'd3, 8'd5, 8'd2, 20'd10);
        tick();
        check("t1_validOut_first", 32'(validOut), 0);
        check("t1_coefOut", 32'(CoefficientOut), 3);
        check("t1_loadOut", 32'(loadOut), 1);
        check("t1_xOut", 32'(xOut), 5);
        check("t1_xDelayOut", 32'(xDelayOut), 2);
        drive(1, 0, 1, 8'd0, 8'd2, 8'd5, 20'd0);
        tick();
        check("t1_zOut", 32'(zOut), 31);
        check("t1_validOut", 32'(validOut), 1);
        check("t1_ovf", 32'(ovf), 0);
        check("t2_selOut", 32'(sumDiffSelOut), 1);
        drive(1, 1, 1, 8'h80, 8'h80, 8'h7F, 20'd0);
        tick();
        check("t2_zOut_diff", 32'(zOut), 32'h000FFFF7);
        drive(0, 0, 0, 8'd0, 8'd0, 8'd0, 20'd0);
        tick();
        check("t2_zOut_extreme", 32'(zOut), 32640);
        check("t2_zOutS_extreme", 32'(zOutS), 32640);
        check("t2_ovfS_extreme", 32'(ovfS), 0);
        tick();
        check("t2_validOut_idle", 32'(validOut), 0);
        check("t2_zOut_idle", 32'(zOut), 0);

        // Stream 0..7 with a 3-cycle stall in front of sample 3.
        for (int k = 0; k < 8; k++) begin
            if (k == 3) begin
                en = 1'b0;
                drive(1, 1, 1, 8'h55, 8'd99, 8'd99, 20'h12345);
                for (int s = 0; s < 3; s++) begin
                    tick();
                    check("t3_stall_zOut", 32'(zOut), 32'(expZ(1)));
                    check("t3_stall_validOut", 32'(validOut), 1);
                    check("t3_stall_xOut", 32'(xOut), 2);
                end
                en = 1'b1;
            end
            drive(1, 0, 0, 8'd0, 8'(k), 8'd1, 20'(100 * k));
            tick();
            if (k >= 1) begin
                check("t3_zOut", 32'(zOut), 32'(expZ(k - 1)));
                check("t3_validOut", 32'(validOut), 1);
            end
        end
        drive(0, 0, 0, 8'd0, 8'd0, 8'd0, 20'd0);
        tick();
        check("t3_zOut_last", 32'(zOut), 32'(expZ(7)));

        // Reset with samples in flight; coefficient register must come back as 0.
        drive(1, 1, 0, 8'd7, 8'd1, 8'd1, 20'd5);
        tick();
        drive(1, 0, 0, 8'd0, 8'd2, 8'd0, 20'd0);
        tick();
        check("t5_zOut_pre", 32'(zOut), 19);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_zOut", 32'(zOut), 0);
        check("t5_rst_validOut", 32'(validOut), 0);
        check("t5_rst_xOut", 32'(xOut), 0);
        check("t5_rst_coefOut", 32'(CoefficientOut), 0);
        tick();
        #2 rst_n = 1'b1;
        drive(1, 0, 0, 8'd0, 8'd3, 8'd0, 20'd4);
        tick();
        check("t5_validOut_first", 32'(validOut), 0);
        drive(1, 1, 0, 8'd2, 8'd1, 8'd1, 20'd5);
        tick();
        check("t5_zOut_coef0", 32'(zOut), 4);
        check("t5_validOut", 32'(validOut), 1);
        drive(1, 0, 0, 8'd0, 8'd3, 8'd0, 20'd0);
        tick();
        check("t5_zOut_load", 32'(zOut), 9);
        drive(0, 0, 0, 8'd0, 8'd0, 8'd0, 20'd0);
        tick();
        check("t5_zOut_held", 32'(zOut), 6);

        // Positive overflow on the 16-bit PEs; the 20-bit PE absorbs it.
        drive(1, 1, 0, 8'd127, 8'd127, 8'd127, 20'd32767);
        tick();
        tick();
        check("t4_zOutS_sat", 32'(zOutS), 32'h7FFF);
        check("t4_ovfS", 32'(ovfS), 1);
        check("t4_zOutW_wrap", 32'(zOutW), 32'hFE01);
        check("t4_ovfW", 32'(ovfW), 1);
        check("t4_zOut_wide", 32'(zOut), 65025);
        check("t4_ovf_wide", 32'(ovf), 0);
        drive(0, 0, 0, 8'd0, 8'd0, 8'd0, 20'd0);
        clrOvf = 1'b1;
        tick();
        check("t4_set_wins_S", 32'(ovfS), 1);
        check("t4_set_wins_W", 32'(ovfW), 1);
        en = 1'b0;
        tick();
        check("t4_clr_stalled", 32'(ovfS), 1);
        en = 1'b1;
        tick();
        check("t4_clr_S", 32'(ovfS), 0);
        check("t4_clr_W", 32'(ovfW), 0);
        clrOvf = 1'b0;

        // Negative overflow: (-128 - 127) * 127 + (-32768).
        drive(1, 0, 1, 8'd0, 8'h80, 8'h7F, 20'hF8000);
        tick();
        drive(0, 0, 0, 8'd0, 8'd0, 8'd0, 20'd0);
        tick();
        check("t4_neg_zOutS", 32'(zOutS), 32'h8000);
        check("t4_neg_ovfS", 32'(ovfS), 1);
        check("t4_neg_zOutW", 32'(zOutW), 32'h017F);
        check("t4_neg_zOut_wide", 32'(zOut), 32'hF017F);
        check("t4_neg_ovf_wide", 32'(ovf), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
